// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Requests one 32-bit word at PC, holds it for decode until accepted, then
// advances PC sequentially or to a branch target. A memory that never answers
// or a misaligned redirect parks the unit in a sticky fault state.

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction memory
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    // Decode side
    output logic [31:0] Instr,
    output logic [63:0] PC_out,
    output logic        instr_valid,
    input  logic        instr_ready,

    // Redirect, sampled only when decode accepts the instruction
    input  logic        PCSrc,
    input  logic        BranchSrc,
    input  logic [63:0] PCBranch,
    input  logic [63:0] RegTarget,

    output logic        fault
);

    typedef enum logic [1:0] {
        StFetch,
        StValid,
        StFault
    } state_t;

    // Last wait count at which a late imem_ready is still accepted.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_t      state;
    logic [63:0] pc;
    logic [7:0]  wait_cnt;

    logic [63:0] pc_seq;
    logic [63:0] branch_target;
    logic [63:0] next_pc;
    logic        next_misaligned;

    // The request address is the architectural PC itself.
    assign imem_addr = pc;

    // Next-PC selection; the 64-bit add wraps naturally at the top of memory.
    always_comb begin
        pc_seq          = pc + 64'd4;
        branch_target   = BranchSrc ? RegTarget : PCBranch;
        next_pc         = PCSrc ? branch_target : pc_seq;
        next_misaligned = |next_pc[1:0];
    end

    // Fetch FSM with registered outputs; reset discards any held instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            wait_cnt    <= 8'd0;
            Instr       <= 32'h0;
            PC_out      <= RESET_PC;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                StFetch: begin
                    if (imem_ready) begin
                        Instr       <= imem_rdata;
                        PC_out      <= pc;
                        wait_cnt    <= 8'd0;
                        state       <= StValid;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (wait_cnt == WaitLast) begin
                        // Counter would reach TIMEOUT this edge: give up.
                        state    <= StFault;
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                StValid: begin
                    // Redirect inputs only matter in the handshake cycle.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            state <= StFault;
                            fault <= 1'b1;
                        end else begin
                            pc       <= next_pc;
                            state    <= StFetch;
                            imem_req <= 1'b1;
                        end
                    end
                end

                StFault: begin
                    // Absorbing until reset.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end

                default: begin
                    state       <= StFault;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven checks of fetch_unit with TIMEOUT=3.

module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [63:0] PC_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic        BranchSrc;
    logic [63:0] PCBranch;
    logic [63:0] RegTarget;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC (64'h0),
        .TIMEOUT  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC_out      (PC_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .BranchSrc   (BranchSrc),
        .PCBranch    (PCBranch),
        .RegTarget   (RegTarget),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A0 = 32'h8B02_0001;
    localparam logic [31:0] A1 = 32'hCB03_0002;
    localparam logic [31:0] A2 = 32'hB400_0043;
    localparam logic [31:0] A3 = 32'h1400_0004;
    localparam logic [31:0] A4 = 32'hD61F_0005;
    localparam logic [31:0] A5 = 32'hF840_0006;
    localparam logic [31:0] A6 = 32'hF800_0007;
    localparam logic [31:0] A7 = 32'h9100_0008;
    localparam logic [31:0] A8 = 32'hAA01_0009;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        ir;
        logic        pcsrc;
        logic        bsrc;
        logic [63:0] pcb;
        logic [63:0] rt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_fault;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic ir,
                         input logic pcsrc, input logic bsrc, input logic [63:0] pcb,
                         input logic [63:0] rt);
        imem_ready  = rdy;
        imem_rdata  = rdata;
        instr_ready = ir;
        PCSrc       = pcsrc;
        BranchSrc   = bsrc;
        PCBranch    = pcb;
        RegTarget   = rt;
    endtask

    // Asserts reset for two cycles and releases it on a falling edge; the
    // half-cycle after release is cycle 0 of the following sequence.
    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //          rdy rdata          ir pcs bs pcb       rt        req addr      vld instr pc        flt
        vecs[0]  = '{1, A0,            1, 0, 0, 64'h0,    64'h0,    1, 64'h0,    0, 32'h0, 64'h0,   0};
        vecs[1]  = '{1, 32'hDEAD_BEEF, 1, 0, 0, 64'h0,    64'h0,    0, 64'h0,    1, A0,    64'h0,   0};
        vecs[2]  = '{1, A1,            1, 0, 0, 64'h0,    64'h0,    1, 64'h4,    0, A0,    64'h0,   0};
        vecs[3]  = '{0, 32'h0,         1, 0, 0, 64'h0,    64'h0,    0, 64'h4,    1, A1,    64'h4,   0};
        vecs[4]  = '{1, A2,            0, 0, 0, 64'h0,    64'h0,    1, 64'h8,    0, A1,    64'h4,   0};
        vecs[5]  = '{0, 32'h0,         1, 1, 0, 64'h40,   64'h100,  0, 64'h8,    1, A2,    64'h8,   0};
        vecs[6]  = '{1, A3,            1, 0, 0, 64'h0,    64'h0,    1, 64'h40,   0, A2,    64'h8,   0};
        vecs[7]  = '{0, 32'h0,         1, 1, 1, 64'h44,   64'h100,  0, 64'h40,   1, A3,    64'h40,  0};
        vecs[8]  = '{1, A4,            1, 0, 0, 64'h0,    64'h0,    1, 64'h100,  0, A3,    64'h40,  0};
        // Backpressure: five cycles with redirects and memory data that must be ignored.
        vecs[9]  = '{1, 32'h1111_0000, 0, 1, 0, 64'h200,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        vecs[10] = '{1, 32'h1111_0001, 0, 0, 0, 64'h200,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        vecs[11] = '{1, 32'h1111_0002, 0, 1, 1, 64'h200,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        vecs[12] = '{0, 32'h1111_0003, 0, 0, 1, 64'h200,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        vecs[13] = '{1, 32'h1111_0004, 0, 1, 0, 64'h202,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        vecs[14] = '{0, 32'h0,         1, 0, 1, 64'h200,  64'h300,  0, 64'h100,  1, A4,    64'h100, 0};
        // Two idle wait cycles, then data at counter == TIMEOUT-1 still succeeds.
        vecs[15] = '{0, 32'h0,         0, 1, 0, 64'h200,  64'h0,    1, 64'h104,  0, A4,    64'h100, 0};
        vecs[16] = '{0, 32'h0,         0, 0, 0, 64'h0,    64'h0,    1, 64'h104,  0, A4,    64'h100, 0};
        vecs[17] = '{1, A5,            0, 0, 0, 64'h0,    64'h0,    1, 64'h104,  0, A4,    64'h100, 0};
        // Branch to the last word, then wrap to 0.
        vecs[18] = '{0, 32'h0,         1, 1, 0, TOP,      64'h0,    0, 64'h104,  1, A5,    64'h104, 0};
        vecs[19] = '{1, A6,            1, 0, 0, 64'h0,    64'h0,    1, TOP,      0, A5,    64'h104, 0};
        vecs[20] = '{0, 32'h0,         1, 0, 0, 64'h0,    64'h0,    0, TOP,      1, A6,    TOP,     0};
        vecs[21] = '{1, A7,            1, 0, 0, 64'h0,    64'h0,    1, 64'h0,    0, A6,    TOP,     0};
        vecs[22] = '{0, 32'h0,         1, 0, 0, 64'h0,    64'h0,    0, 64'h0,    1, A7,    64'h0,   0};
        vecs[23] = '{1, A8,            1, 0, 0, 64'h0,    64'h0,    1, 64'h4,    0, A7,    64'h0,   0};
        // Misaligned target: fault, PC stays at 4.
        vecs[24] = '{0, 32'h0,         1, 1, 0, 64'h42,   64'h0,    0, 64'h4,    1, A8,    64'h4,   0};
        vecs[25] = '{1, A0,            1, 1, 0, 64'h40,   64'h0,    0, 64'h4,    0, A8,    64'h4,   1};
        vecs[26] = '{1, A1,            1, 0, 0, 64'h0,    64'h0,    0, 64'h4,    0, A8,    64'h4,   1};

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

        // Table-driven main sequence.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rdy, vecs[i].rdata, vecs[i].ir, vecs[i].pcsrc, vecs[i].bsrc,
                  vecs[i].pcb, vecs[i].rt);
            chk($sformatf("v%0d.req", i),   {63'h0, imem_req},    {63'h0, vecs[i].e_req});
            chk($sformatf("v%0d.addr", i),  imem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d.valid", i), {63'h0, instr_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("v%0d.instr", i), {32'h0, Instr},       {32'h0, vecs[i].e_instr});
            chk($sformatf("v%0d.pc", i),    PC_out,               vecs[i].e_pc);
            chk($sformatf("v%0d.fault", i), {63'h0, fault},       {63'h0, vecs[i].e_fault});
            @(negedge clk);
        end

        // Reset clears a sticky fault asynchronously.
        reset = 1'b1;
        #1;
        chk("rst_clears_fault", {63'h0, fault}, 64'h0);
        chk("rst_instr", {32'h0, Instr}, 64'h0);
        chk("rst_req", {63'h0, imem_req}, 64'h1);

        // Timeout with imem_ready held low.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
            chk($sformatf("tmo%0d.fault", c), {63'h0, fault}, (c >= 3) ? 64'h1 : 64'h0);
            chk($sformatf("tmo%0d.req", c), {63'h0, imem_req}, (c >= 3) ? 64'h0 : 64'h1);
            chk($sformatf("tmo%0d.valid", c), {63'h0, instr_valid}, 64'h0);
            @(negedge clk);
        end

        // Reset in VALID with a pending redirect.
        do_reset();
        drive(1'b1, A2, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        @(negedge clk);
        chk("rv.valid_before", {63'h0, instr_valid}, 64'h1);
        chk("rv.instr_before", {32'h0, Instr}, {32'h0, A2});
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 64'h80, 64'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("rv.valid_async", {63'h0, instr_valid}, 64'h0);
        chk("rv.instr_async", {32'h0, Instr}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, A3, 1'b1, 1'b1, 1'b0, 64'h80, 64'h0);
        chk("rv.addr_after", imem_addr, 64'h0);
        chk("rv.req_after", {63'h0, imem_req}, 64'h1);
        chk("rv.valid_after", {63'h0, instr_valid}, 64'h0);
        @(negedge clk);
        chk("rv.instr_fetch", {32'h0, Instr}, {32'h0, A3});
        chk("rv.pc_fetch", PC_out, 64'h0);
        @(negedge clk);
        // Redirect to 0x80 was taken at that handshake, not the discarded one.
        chk("rv.addr_branch", imem_addr, 64'h80);
        chk("rv.fault_end", {63'h0, fault}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles imem_req may wait for imem_ready, range 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  64  byte address of requested word, always equal to PC.
REQ-008 imem_ready  input  1  imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 Instr  output  32  held instruction; Instr[31:21] drives decoder Op.
REQ-011 PC_out  output  64  address of Instr.
REQ-012 instr_valid  output  1  Instr/PC_out valid for decode.
REQ-013 instr_ready  input  1  decode accepts Instr this cycle.
REQ-014 PCSrc  input  1  taken branch for accepted instruction (Branch&zero | Uncondbranch).
REQ-015 BranchSrc  input  1  1: target from RegTarget (BR); 0: from PCBranch.
REQ-016 PCBranch  input  64  PC-relative branch target.
REQ-017 RegTarget  input  64  register branch target.
REQ-018 fault  output  1  sticky fault flag.

Function
REQ-019 SHALL implement states FETCH, VALID, FAULT; reset state FETCH.
REQ-020 In FETCH: imem_req=1, instr_valid=0; wait counter increments each cycle imem_ready=0.
REQ-021 In FETCH with imem_ready=1: Instr<=imem_rdata, PC_out<=PC, counter<=0, next state VALID; instr_valid rises the following cycle (1-cycle latency from imem_ready).
REQ-022 In FETCH, if counter reaches TIMEOUT with imem_ready=0, next state FAULT; imem_ready in the same cycle the counter equals TIMEOUT-1 still succeeds.
REQ-023 In VALID: imem_req=0, instr_valid=1, Instr and PC_out stable until handshake.
REQ-024 Handshake = instr_valid & instr_ready; PCSrc/BranchSrc/PCBranch/RegTarget sampled only in the handshake cycle, ignored otherwise.
REQ-025 On handshake, next PC = PCSrc ? (BranchSrc ? RegTarget : PCBranch) : PC+4; next state FETCH.
REQ-026 PC+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0) without fault.
REQ-027 If selected next PC has bits[1:0] != 0, PC SHALL not update and next state FAULT.
REQ-028 FAULT: fault=1, imem_req=0, instr_valid=0; absorbing until reset.
REQ-029 Minimum throughput SHALL be one instruction per 2 cycles (imem_ready=1 and instr_ready=1 always).
REQ-030 imem_ready while not in FETCH SHALL be ignored.

Reset
REQ-031 Reset SHALL force: PC=RESET_PC, state FETCH, Instr=32'h0, PC_out=RESET_PC, instr_valid=0, fault=0, counter=0; imem_req=1 from the first cycle after reset deasserts.
REQ-032 Reset asserted mid-wait or mid-VALID SHALL discard the held instruction and pending redirect immediately (asynchronously).

Verification
REQ-033 Sequential: imem_ready=1, instr_ready=1, PCSrc=0 -> imem_addr 0,4,8 on cycles 0,2,4; instr_valid high on cycles 1,3,5.
REQ-034 Branch: accept at PC=8 with PCSrc=1, BranchSrc=0, PCBranch=0x40 -> next imem_addr=0x40; with BranchSrc=1, RegTarget=0x100 -> 0x100.
REQ-035 Backpressure: instr_ready=0 for 5 cycles in VALID -> Instr/PC_out unchanged, imem_req=0, PCSrc toggling has no effect.
REQ-036 Timeout: TIMEOUT=3, imem_ready held 0 -> fault=1 on cycle 3 after FETCH entry, remains 1; imem_ready at cycle 2 -> normal fetch.
REQ-037 Misaligned: PCSrc=1, PCBranch=0x42 -> fault=1, PC remains at prior value.
REQ-038 Reset mid-operation and wrap: reset in VALID -> instr_valid=0 and imem_addr=RESET_PC next cycle; PC=64'hFFFF_FFFF_FFFF_FFFC sequential -> imem_addr=0, fault=0.
